fsmc_bus_master: RTL

FSMC_BUS_MASTER -- requirements
Module: fsmc_bus_master

---
 rtl/fsmc_bus_master_pkg.sv | 22 ++
 rtl/fsmc_bus_master_if.sv | 32 +++
 rtl/fsmc_phase_timer.sv | 26 ++
 rtl/fsmc_bus_master.sv | 130 +++++++++++++
 4 files changed

// File: rtl/fsmc_bus_master_pkg.sv
// Shared FSMC definitions: master state encoding, phase counter width and
// the peripheral register map seen by both the master and the slave side.
package fsmc_bus_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } fsmc_state_t;

  localparam int unsigned PHASE_W = 4;

  localparam logic [7:0] ADR_LOW  = 8'h00;
  localparam logic [7:0] ADR_HIGH = 8'h01;
  localparam logic [7:0] DATA     = 8'h02;

  function automatic bit phase_len_ok(input int unsigned len);
    return (len >= 1) && (len <= 15);
  endfunction

endpackage

// File: rtl/fsmc_bus_master_if.sv
// Local request/response handshake plus the FSMC pad-side signals.
interface fsmc_bus_master_if #(
  parameter int unsigned ADRW = 8,
  parameter int unsigned DATW = 16
);
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [ADRW-1:0] req_adr;
  logic [DATW-1:0] req_wdata;
  logic            rsp_valid;
  logic [DATW-1:0] rsp_rdata;
  logic            aNE;
  logic            aNOE;
  logic            aNWE;
  logic [ADRW-1:0] aA;
  logic [DATW-1:0] d_out;
  logic [DATW-1:0] d_in;
  logic            d_oe;

  modport master (
    input  req_valid, req_write, req_adr, req_wdata, d_in,
    output req_ready, rsp_valid, rsp_rdata,
    output aNE, aNOE, aNWE, aA, d_out, d_oe
  );

  modport slave (
    output req_valid, req_write, req_adr, req_wdata, d_in,
    input  req_ready, rsp_valid, rsp_rdata,
    input  aNE, aNOE, aNWE, aA, d_out, d_oe
  );
endinterface

// File: rtl/fsmc_phase_timer.sv
// Down-counter shared by all bus phases: load length-1, flag when at zero.
module fsmc_phase_timer
  import fsmc_bus_master_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [PHASE_W-1:0] i_value,
  output logic               o_zero
);

  logic [PHASE_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/fsmc_bus_master.sv
// FSMC asynchronous-SRAM style bus master: one request at a time through
// SETUP / STROBE / HOLD phases, every pad output driven from a flop.
module fsmc_bus_master
  import fsmc_bus_master_pkg::*;
#(
  parameter int unsigned ADRW   = 8,
  parameter int unsigned DATW   = 16,
  parameter int unsigned ADDSET = 2,
  parameter int unsigned DATAST = 3,
  parameter int unsigned HOLD   = 1
) (
  input logic               clk,
  input logic               rst,
  fsmc_bus_master_if.master bus
);

  if (!phase_len_ok(ADDSET) || !phase_len_ok(DATAST) || !phase_len_ok(HOLD)) begin : g_bad_timing
    $fatal(1, "fsmc_bus_master: ADDSET, DATAST and HOLD must each be in 1..15");
  end

  if ($bits(bus.aA) != ADRW || $bits(bus.d_out) != DATW) begin : g_bad_width
    $fatal(1, "fsmc_bus_master: interface widths do not match ADRW/DATW");
  end

  localparam logic [PHASE_W-1:0] LD_SETUP  = PHASE_W'(ADDSET - 1);
  localparam logic [PHASE_W-1:0] LD_STROBE = PHASE_W'(DATAST - 1);
  localparam logic [PHASE_W-1:0] LD_HOLD   = PHASE_W'(HOLD - 1);

  fsmc_state_t        r_state;
  fsmc_state_t        w_state_nxt;
  logic               r_write;
  logic               w_accept;
  logic               w_zero;
  logic               w_load;
  logic [PHASE_W-1:0] w_load_val;
  logic               w_write_nxt;
  logic               w_ne_nxt;
  logic               w_noe_nxt;
  logic               w_nwe_nxt;
  logic               w_oe_nxt;
  logic               w_rsp_nxt;
  logic               w_capture;

  assign bus.req_ready = (r_state == ST_IDLE);
  assign w_accept      = bus.req_valid && (r_state == ST_IDLE);

  fsmc_phase_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_zero  (w_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = '0;
    unique case (r_state)
      ST_IDLE: if (w_accept) begin
        w_state_nxt = ST_SETUP;
        w_load      = 1'b1;
        w_load_val  = LD_SETUP;
      end
      ST_SETUP: if (w_zero) begin
        w_state_nxt = ST_STROBE;
        w_load      = 1'b1;
        w_load_val  = LD_STROBE;
      end
      ST_STROBE: if (w_zero) begin
        w_state_nxt = ST_HOLD;
        w_load      = 1'b1;
        w_load_val  = LD_HOLD;
      end
      ST_HOLD: if (w_zero) begin
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Pad values are decoded from the upcoming state and then registered, so
  // each pad flop tracks r_state exactly while having no input-to-pad path.
  always_comb begin
    w_write_nxt = w_accept ? bus.req_write : r_write;
    w_ne_nxt    = (w_state_nxt == ST_IDLE);
    w_noe_nxt   = !((w_state_nxt == ST_STROBE) && !w_write_nxt);
    w_nwe_nxt   = !((w_state_nxt == ST_STROBE) && w_write_nxt);
    w_oe_nxt    = (w_state_nxt != ST_IDLE) && w_write_nxt;
    w_rsp_nxt   = (r_state == ST_HOLD) && (w_state_nxt == ST_IDLE);
    w_capture   = (r_state == ST_STROBE) && w_zero && !r_write;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_write       <= 1'b0;
      bus.aNE       <= 1'b1;
      bus.aNOE      <= 1'b1;
      bus.aNWE      <= 1'b1;
      bus.d_oe      <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.aA        <= '0;
      bus.d_out     <= '0;
      bus.rsp_rdata <= '0;
    end else begin
      r_write       <= w_write_nxt;
      bus.aNE       <= w_ne_nxt;
      bus.aNOE      <= w_noe_nxt;
      bus.aNWE      <= w_nwe_nxt;
      bus.d_oe      <= w_oe_nxt;
      bus.rsp_valid <= w_rsp_nxt;
      if (w_accept) begin
        bus.aA    <= bus.req_adr;
        bus.d_out <= bus.req_wdata;
      end
      if (w_capture) begin
        bus.rsp_rdata <= bus.d_in;
      end
    end
  end

endmodule
